alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised, registered successor to the 8-bit adder/subtractor ALU of the eater CPU.
//   Adds carry-chained ops (ADC/SBC), bitwise logic and a 4-bit flags register.
//   An optional iterative multiplier is compiled in by macro.
//   Sits between the A/B registers and the shared bus; the control unit drives it via start/busy/done.
// PARAMETERS
//   WIDTH  8  datapath width in bits (>=2); a, b, result, bus are all WIDTH wide
// PORTS
//   clk          in   1      rising-edge clock
//   clear_n      in   1      asynchronous active-low reset
//   start        in   1      launch op; sampled on rising edge only while busy=0
//   op           in   3      000 ADD,001 SUB,010 ADC,011 SBC,100 AND,101 OR,110 XOR,111 MUL
//   update_flags in   1      sampled with start; 1 = write flags on completion
//   a, b         in   WIDTH  operands; captured at the accepting edge
//   out_en       in   1      1 = drive result onto bus
//   bus          out  WIDTH  result when out_en=1, else 'z (combinational on out_en)
//   flags        out  4      {V,N,C,Z}: flags[0]=zero, flags[1]=carry/borrow, [2]=neg, [3]=ovf
//   busy         out  1      multi-cycle op in progress
//   done         out  1      one-cycle pulse: result (and flags if enabled) updated
// BEHAVIOUR
//   Reset (clear_n=0, async, any time incl. mid-multiply): result=0, flags=0, busy=0, done=0,
//     FSM->IDLE, operand/count regs=0; any in-flight op is discarded.
//   Single-cycle ops (000-110): accepted at edge k; result/flags/done registered at edge k;
//     done=1 for the cycle after k. Holding start=1 gives one op per cycle.
//   ADD: a+b.  SUB: a-b.  ADC: a+b+C.  SBC: a-b-C (C = current flags[1]).
//   C: carry-out for ADD/ADC; borrow for SUB/SBC (1 when a < b+borrow_in, unsigned).
//   V: signed overflow (ADD: sign(a)==sign(b)!=sign(r); SUB: sign(a)!=sign(b), sign(r)!=sign(a)).
//   Logic ops: C=0, V=0.  All ops: Z=(r==0), N=r[WIDTH-1].
//   update_flags=0: flags hold; result still written.
//   FSM: IDLE --start&op==MUL--> MUL (cnt=0) --cnt==WIDTH-1--> IDLE.
//   MUL: shift-add, one partial product per cycle; accepted at edge k, busy=1 after k.
//     At edge k+WIDTH: busy=0, done=1, result = low WIDTH bits of a*b.
//     C=V=(high half != 0); Z, N from the low half.
//   start while busy=1: ignored (no queueing). op/a/b changes while busy: no effect.
//   Start accepted at the edge immediately after done rises (busy already 0).
//   result holds between ops; bus follows result while out_en=1.
// CONFIGURATION
//   ALU_MUL_EN defined: op 111 = iterative multiply as above; FSM and counter present.
//   ALU_MUL_EN undefined: no FSM; busy tied 0.
//     op 111 = NOP: done pulses after 1 cycle; result and flags unchanged.
// TESTING
//   1 clear_n=0 mid-op, out_en=0 -> flags=0, busy=0, done=0, bus=z; after release out_en=1 -> bus=0.
//   2 ADD a=0x80 b=0x80 upd=1 -> done next cycle, result=0x00, flags=4'b1011; out_en=1 -> bus=0x00.
//   3 SUB a=224 b=53 upd=1 -> result=171 (0xAB), flags=4'b0100; repeat with upd=0 -> flags hold.
//   4 SUB 123-124 upd=1 -> 0xFF, flags=4'b0110; then ADC 0x01+0x01 -> 0x03, C=0.
//   5 (ALU_MUL_EN) MUL 15*17 -> done exactly 8 edges after start, 0xFF, C=0.
//     MUL 16*16 -> 0x00, flags=4'b1011; start during busy ignored.
//   6 (ALU_MUL_EN) clear_n low at cycle 3 of MUL -> immediate busy=0, no done.
//     Without macro: op 111 -> done after 1 cycle, result/flags unchanged.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: control/operand/bus signal bundle between the control unit and alu_seq
interface alu_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [2:0]       op;
    logic             update_flags;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_en;
    logic [WIDTH-1:0] bus;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    modport slave (
        input  start, op, update_flags, a, b, out_en,
        output bus, flags, busy, done
    );

    modport master (
        output start, op, update_flags, a, b, out_en,
        input  bus, flags, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ADD/SUB/ADC/SBC/AND/OR/XOR ALU with {V,N,C,Z} flags; ALU_MUL_EN adds an iterative shift-add multiply on op 111
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     clear_n,
    alu_seq_if.slave alu
);
    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_done;
    logic             w_cin;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_flg;
    logic             w_accept;

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t             r_state;
    logic               r_busy;
    logic               r_upd;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mc;
    logic [WIDTH-1:0]   r_mp;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc;
    logic [3:0]         w_mflg;
`endif

    // Single-cycle datapath: carry-chained add/subtract and bitwise logic
    always_comb begin
        w_cin = alu.op[1] & r_flags[1];
        w_add = {1'b0, alu.a} + {1'b0, alu.b} + {{WIDTH{1'b0}}, w_cin};
        w_sub = {1'b0, alu.a} - {1'b0, alu.b} - {{WIDTH{1'b0}}, w_cin};
        w_res = r_result;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (alu.op)
            3'b000, 3'b010: begin
                w_res = w_add[M:0];
                w_c   = w_add[WIDTH];
                w_v   = (alu.a[M] == alu.b[M]) && (w_add[M] != alu.a[M]);
            end
            3'b001, 3'b011: begin
                w_res = w_sub[M:0];
                w_c   = w_sub[WIDTH];
                w_v   = (alu.a[M] != alu.b[M]) && (w_sub[M] != alu.a[M]);
            end
            3'b100:  w_res = alu.a & alu.b;
            3'b101:  w_res = alu.a | alu.b;
            3'b110:  w_res = alu.a ^ alu.b;
            default: w_res = r_result;
        endcase
        w_flg = {w_v, w_res[M], w_c, w_res == '0};
    end

`ifdef ALU_MUL_EN
    assign w_accept = alu.start && !r_busy;

    // Next partial-product sum and the flags the final step would produce
    always_comb begin
        w_acc  = r_acc + (r_mp[0] ? r_mc : '0);
        w_mflg = {|w_acc[2*WIDTH-1:WIDTH], w_acc[M], |w_acc[2*WIDTH-1:WIDTH], w_acc[M:0] == '0};
    end

    // Op acceptance, multiply FSM and result/flags/done registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_upd    <= 1'b0;
            r_cnt    <= '0;
            r_mc     <= '0;
            r_mp     <= '0;
            r_acc    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && alu.op == 3'b111) begin
                        r_state <= S_MUL;
                        r_busy  <= 1'b1;
                        r_upd   <= alu.update_flags;
                        r_cnt   <= '0;
                        r_mc    <= {{WIDTH{1'b0}}, alu.a};
                        r_mp    <= alu.b;
                        r_acc   <= '0;
                    end else if (w_accept) begin
                        r_result <= w_res;
                        r_done   <= 1'b1;
                        if (alu.update_flags)
                            r_flags <= w_flg;
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc;
                    r_mc  <= r_mc << 1;
                    r_mp  <= r_mp >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(M)) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_acc[M:0];
                        if (r_upd)
                            r_flags <= w_mflg;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu.busy = r_busy;
`else
    assign w_accept = alu.start;

    // Op acceptance; op 111 only pulses done and leaves result and flags alone
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_done <= w_accept;
            if (w_accept && alu.op != 3'b111) begin
                r_result <= w_res;
                if (alu.update_flags)
                    r_flags <= w_flg;
            end
        end
    end

    assign alu.busy = 1'b0;
`endif

    assign alu.flags = r_flags;
    assign alu.done  = r_done;
    assign alu.bus   = alu.out_en ? r_result : 'z;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq
module tb_alu_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    int   n_tot = 0;
    int   n_bad = 0;
    int   n;

    alu_seq_if #(.WIDTH(W)) ifc();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .clear_n(clear_n), .alu(ifc));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic u);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op = o;
        ifc.a = x;
        ifc.b = y;
        ifc.update_flags = u;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
    endtask

    task automatic op_chk(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic u, input logic [W-1:0] r, input logic [3:0] f);
        run(o, x, y, u);
        check({tag, "_done"}, ifc.done, 1);
        check({tag, "_res"}, ifc.bus, r);
        check({tag, "_flg"}, ifc.flags, f);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!ifc.done && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("done_timeout", ifc.done, 1);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.op = 3'b000;
        ifc.update_flags = 1'b0;
        ifc.a = '0;
        ifc.b = '0;
        ifc.out_en = 1'b1;
        #12 clear_n = 1'b1;
        op_chk("pre", 3'b000, 8'd3, 8'd4, 1'b1, 8'd7, 4'b0000);
        op_chk("pre_neg", 3'b001, 8'd0, 8'd1, 1'b1, 8'hFF, 4'b0110);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op = 3'b000;
        ifc.a = 8'd1;
        ifc.b = 8'd2;
        ifc.out_en = 1'b0;
        #2 clear_n = 1'b0;
        #1;
        check("rst_flags", ifc.flags, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_done", ifc.done, 0);
        ifc.start = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        ifc.out_en = 1'b1;
        #1;
        check("rst_bus", ifc.bus, 0);

        op_chk("add80", 3'b000, 8'h80, 8'h80, 1'b1, 8'h00, 4'b1011);
        @(posedge clk);
        #1;
        check("add_pulse", ifc.done, 0);
        op_chk("sub", 3'b001, 8'd224, 8'd53, 1'b1, 8'hAB, 4'b0100);
        op_chk("sub_noupd", 3'b001, 8'd5, 8'd5, 1'b0, 8'h00, 4'b0100);
        op_chk("sub_brw", 3'b001, 8'd123, 8'd124, 1'b1, 8'hFF, 4'b0110);
        op_chk("adc", 3'b010, 8'h01, 8'h01, 1'b1, 8'h03, 4'b0000);
        op_chk("sub_c1", 3'b001, 8'd0, 8'd1, 1'b1, 8'hFF, 4'b0110);
        op_chk("sbc", 3'b011, 8'd5, 8'd2, 1'b1, 8'h02, 4'b0000);
        op_chk("sub_c2", 3'b001, 8'd0, 8'd1, 1'b1, 8'hFF, 4'b0110);
        op_chk("and", 3'b100, 8'hF0, 8'h0F, 1'b1, 8'h00, 4'b0001);
        op_chk("or", 3'b101, 8'h80, 8'h01, 1'b1, 8'h81, 4'b0100);
        op_chk("sub_ovf", 3'b001, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1000);
        op_chk("xor", 3'b110, 8'hFF, 8'h0F, 1'b1, 8'hF0, 4'b0100);

        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op = 3'b000;
        ifc.a = 8'd1;
        ifc.b = 8'd1;
        ifc.update_flags = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_done1", ifc.done, 1);
        check("b2b_res1", ifc.bus, 8'd2);
        ifc.a = 8'd2;
        ifc.b = 8'd3;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        check("b2b_done2", ifc.done, 1);
        check("b2b_res2", ifc.bus, 8'd5);
        @(posedge clk);
        #1;
        check("b2b_idle", ifc.done, 0);

`ifdef ALU_MUL_EN
        run(3'b111, 8'd15, 8'd17, 1'b1);
        check("mul1_busy", ifc.busy, 1);
        check("mul1_nodone", ifc.done, 0);
        wait_done(n);
        check("mul1_lat", n, 8);
        check("mul1_res", ifc.bus, 8'hFF);
        check("mul1_flg", ifc.flags, 4'b0100);
        check("mul1_busy_end", ifc.busy, 0);

        run(3'b111, 8'd16, 8'd16, 1'b1);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op = 3'b000;
        ifc.a = 8'd1;
        ifc.b = 8'd1;
        @(posedge clk);
        #1;
        check("mul2_busy", ifc.busy, 1);
        check("mul2_ign", ifc.done, 0);
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(n);
        check("mul2_lat", n, 7);
        check("mul2_res", ifc.bus, 8'h00);
        check("mul2_flg", ifc.flags, 4'b1011);
        @(posedge clk);
        #1;
        check("mul2_pulse", ifc.done, 0);

        run(3'b111, 8'd3, 8'd3, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        check("mulrst_busy", ifc.busy, 0);
        check("mulrst_done", ifc.done, 0);
        check("mulrst_flg", ifc.flags, 0);
        @(negedge clk);
        clear_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (ifc.done) n++;
        end
        check("mulrst_nodone", n, 0);
        check("mulrst_bus", ifc.bus, 0);
`else
        op_chk("pre_nop", 3'b001, 8'd0, 8'd1, 1'b1, 8'hFF, 4'b0110);
        op_chk("nop", 3'b111, 8'd5, 8'd5, 1'b1, 8'hFF, 4'b0110);
        check("nop_busy", ifc.busy, 0);
        @(posedge clk);
        #1;
        check("nop_pulse", ifc.done, 0);
`endif
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
